// File: rtl/bf2i_pair_feeder.sv
// Input-side pair feeder for the 4-lane radix-2 BF2I butterfly: buffers the first half
// of each frame and presents (x[n], x[n+N/2]) pairs with a one-cycle enable per pair.
module bf2i_pair_feeder #(
  parameter int WIDTH       = 15,
  parameter int DEPTH       = 4,
  parameter int HALF_BLOCKS = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    din_valid,
  input  logic                    frame_start,
  input  logic signed [WIDTH-1:0] din_R    [DEPTH],
  input  logic signed [WIDTH-1:0] din_Q    [DEPTH],
  output logic                    bf_en,
  output logic signed [WIDTH-1:0] dout_R_1 [DEPTH],
  output logic signed [WIDTH-1:0] dout_Q_1 [DEPTH],
  output logic signed [WIDTH-1:0] dout_R_2 [DEPTH],
  output logic signed [WIDTH-1:0] dout_Q_2 [DEPTH],
  output logic                    busy,
  output logic                    frame_err
);

  localparam int CW = (HALF_BLOCKS > 1) ? $clog2(HALF_BLOCKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_BLOCKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PAIR = 2'd2
  } state_t;

  // A one-beat half frame skips FILL entirely.
  localparam state_t        START_ST  = (HALF_BLOCKS == 1) ? PAIR : FILL;
  localparam logic [CW-1:0] START_CNT = (HALF_BLOCKS == 1) ? CW'(0) : CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bf_en_q, bf_en_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic          wr_en;
  logic [CW-1:0] wr_addr;

  logic signed [WIDTH-1:0] mem_R [HALF_BLOCKS][DEPTH];
  logic signed [WIDTH-1:0] mem_Q [HALF_BLOCKS][DEPTH];

  logic signed [WIDTH-1:0] r1_q [DEPTH], r1_d [DEPTH];
  logic signed [WIDTH-1:0] q1_q [DEPTH], q1_d [DEPTH];
  logic signed [WIDTH-1:0] r2_q [DEPTH], r2_d [DEPTH];
  logic signed [WIDTH-1:0] q2_q [DEPTH], q2_d [DEPTH];

  // Next-state, counter, buffer-write and pair-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bf_en_d = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = cnt_q;
    r1_d    = r1_q;
    q1_d    = q1_q;
    r2_d    = r2_q;
    q2_d    = q2_q;
    if (din_valid) begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            wr_en   = 1'b1;
            wr_addr = CW'(0);
            state_d = START_ST;
            cnt_d   = START_CNT;
          end else begin
            state_d = IDLE;
          end
        end
        FILL: begin
          wr_en = 1'b1;
          if (frame_start) begin
            // Abort: this beat becomes beat 0 of a fresh frame.
            err_d   = 1'b1;
            wr_addr = CW'(0);
            state_d = START_ST;
            cnt_d   = START_CNT;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = CW'(0);
            state_d = PAIR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PAIR: begin
          if (frame_start) begin
            err_d   = 1'b1;
            wr_en   = 1'b1;
            wr_addr = CW'(0);
            state_d = START_ST;
            cnt_d   = START_CNT;
          end else begin
            bf_en_d = 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
              r1_d[i] = mem_R[cnt_q][i];
              q1_d[i] = mem_Q[cnt_q][i];
              r2_d[i] = din_R[i];
              q2_d[i] = din_Q[i];
            end
            if (cnt_q == CNT_LAST) begin
              cnt_d   = CW'(0);
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CW'(0);
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != IDLE);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= CW'(0);
      bf_en_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r1_q[i] <= WIDTH'(0);
        q1_q[i] <= WIDTH'(0);
        r2_q[i] <= WIDTH'(0);
        q2_q[i] <= WIDTH'(0);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bf_en_q <= bf_en_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      r1_q    <= r1_d;
      q1_q    <= q1_d;
      r2_q    <= r2_d;
      q2_q    <= q2_d;
    end
  end

  // First-half buffer; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_R[wr_addr][i] <= din_R[i];
        mem_Q[wr_addr][i] <= din_Q[i];
      end
    end
  end

  assign bf_en     = bf_en_q;
  assign busy      = busy_q;
  assign frame_err = err_q;
  assign dout_R_1  = r1_q;
  assign dout_Q_1  = q1_q;
  assign dout_R_2  = r2_q;
  assign dout_Q_2  = q2_q;

endmodule

// File: tb/tb_bf2i_pair_feeder.sv
// Directed self-checking bench for bf2i_pair_feeder: reset, continuous, stalled,
// back-to-back, aborted and reset-interrupted frames.
module tb_bf2i_pair_feeder;

  localparam int W = 15;
  localparam int D = 4;

  logic                clk;
  logic                rstn;
  logic                din_valid;
  logic                frame_start;
  logic signed [W-1:0] din_R [D];
  logic signed [W-1:0] din_Q [D];
  logic                bf_en;
  logic signed [W-1:0] dout_R_1 [D];
  logic signed [W-1:0] dout_Q_1 [D];
  logic signed [W-1:0] dout_R_2 [D];
  logic signed [W-1:0] dout_Q_2 [D];
  logic                busy;
  logic                frame_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_pairs = 0;

  bf2i_pair_feeder #(.WIDTH(W), .DEPTH(D), .HALF_BLOCKS(8)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .frame_start(frame_start),
    .din_R(din_R), .din_Q(din_Q), .bf_en(bf_en),
    .dout_R_1(dout_R_1), .dout_Q_1(dout_Q_1), .dout_R_2(dout_R_2), .dout_Q_2(dout_Q_2),
    .busy(busy), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a frame whose lane i carries base+16k+i (Q is the negation).
  task automatic drive(input logic v, input logic fs, input int base, input int k);
    din_valid   = v;
    frame_start = fs;
    for (int i = 0; i < D; i++) begin
      din_R[i] = W'(base + 16 * k + i);
      din_Q[i] = W'(-(base + 16 * k + i));
    end
  endtask

  task automatic drive_junk(input logic fs);
    din_valid   = 1'b0;
    frame_start = fs;
    for (int i = 0; i < D; i++) begin
      din_R[i] = W'($urandom);
      din_Q[i] = W'($urandom);
    end
  endtask

  task automatic chk_pair(input string tag, input int base, input int j);
    for (int i = 0; i < D; i++) begin
      chk({tag, " R1"}, dout_R_1[i], base + 16 * j + i);
      chk({tag, " Q1"}, dout_Q_1[i], -(base + 16 * j + i));
      chk({tag, " R2"}, dout_R_2[i], base + 16 * (j + 8) + i);
      chk({tag, " Q2"}, dout_Q_2[i], -(base + 16 * (j + 8) + i));
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, " bf_en"}, bf_en, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " err"}, frame_err, 0);
    for (int i = 0; i < D; i++) begin
      chk({tag, " R1"}, dout_R_1[i], 0);
      chk({tag, " Q1"}, dout_Q_1[i], 0);
      chk({tag, " R2"}, dout_R_2[i], 0);
      chk({tag, " Q2"}, dout_Q_2[i], 0);
    end
  endtask

  // Full 16-beat frame, optionally with an invalid cycle (frame_start high) after every beat.
  task automatic run_frame(input string tag, input int base, input logic stall);
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, k == 0, base, k);
      tick();
      chk({tag, " bf_en"}, bf_en, (k >= 8) ? 1 : 0);
      chk({tag, " err"}, frame_err, 0);
      chk({tag, " busy"}, busy, (k != 15) ? 1 : 0);
      if (bf_en === 1'b1) n_pairs++;
      if (k >= 8) chk_pair(tag, base, k - 8);
      if (stall) begin
        drive_junk(1'b1);
        tick();
        chk({tag, " gap bf_en"}, bf_en, 0);
        chk({tag, " gap err"}, frame_err, 0);
        chk({tag, " gap busy"}, busy, (k != 15) ? 1 : 0);
        if (k >= 8) chk_pair({tag, " hold"}, base, k - 8);
      end
    end
  endtask

  initial begin
    rstn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      din_valid   = 1'($urandom);
      frame_start = 1'($urandom);
      for (int i = 0; i < D; i++) begin
        din_R[i] = W'($urandom);
        din_Q[i] = W'($urandom);
      end
      tick();
      chk_zero_outs("reset");
    end
    rstn = 1'b1;

    // Valid beats without frame_start are dropped silently.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 100, k);
      tick();
      chk("nostart bf_en", bf_en, 0);
      chk("nostart busy", busy, 0);
      chk("nostart err", frame_err, 0);
    end

    run_frame("cont", 0, 1'b0);
    run_frame("stall", 0, 1'b1);

    n_pairs = 0;
    run_frame("b2b1", 2000, 1'b0);
    run_frame("b2b2", 3000, 1'b0);
    chk("b2b pair count", n_pairs, 16);

    // Abort in PAIR at beat 11: that beat restarts a frame based at 5000.
    for (int k = 0; k < 11; k++) begin
      drive(1'b1, k == 0, 4000, k);
      tick();
      chk("abort pre err", frame_err, 0);
      if (k >= 8) chk_pair("abort pre", 4000, k - 8);
    end
    drive(1'b1, 1'b1, 5000, 0);
    tick();
    chk("abort err", frame_err, 1);
    chk("abort bf_en", bf_en, 0);
    chk("abort busy", busy, 1);
    for (int k = 1; k < 16; k++) begin
      drive(1'b1, 1'b0, 5000, k);
      tick();
      chk("abort post err", frame_err, 0);
      chk("abort post bf_en", bf_en, (k >= 8) ? 1 : 0);
      if (k >= 8) chk_pair("abort post", 5000, k - 8);
    end

    // Reset while FILL holds beats 0..4.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 0, 6000, k);
      tick();
    end
    drive(1'b1, 1'b0, 6000, 5);
    #2;
    rstn = 1'b0;
    tick();
    chk_zero_outs("midrst");
    rstn = 1'b1;
    drive(1'b1, 1'b0, 6000, 6);
    tick();
    chk("midrst stale bf_en", bf_en, 0);
    chk("midrst stale busy", busy, 0);
    drive_junk(1'b0);
    tick();
    chk("midrst idle bf_en", bf_en, 0);
    run_frame("newframe", 7000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
